rover_motion_encoder: RTL and testbench

Generates the 3-bit active-low motion command (bit2, bit1, bit0) that drives the rover motor stage and the rover display decoder. In manual mode the command comes from four debounced direction buttons. In automated mode an obstacle-avoidance FSM produces the command: forward, back up, turn right, resume. This block is the producer of the command code; the display block consumes it.

---
 rtl/rover_pkg.sv | 32 +++
 rtl/rover_debounce.sv | 50 +++++
 rtl/rover_motion_encoder.sv | 125 ++++++++++++
 tb/tb_rover_motion_encoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rover_pkg.sv
// Shared command codes, automated-FSM state encoding and sizing helpers
// for the rover motion command encoder.
package rover_pkg;

  localparam logic [2:0] CMD_STOP  = 3'b000;
  localparam logic [2:0] CMD_FWD   = 3'b001;
  localparam logic [2:0] CMD_BACK  = 3'b010;
  localparam logic [2:0] CMD_LEFT  = 3'b011;
  localparam logic [2:0] CMD_RIGHT = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FORWARD = 3'd1,
    ST_BACKUP  = 3'd2,
    ST_TURN    = 3'd3
  } auto_state_e;

  // Width of a down/up counter that must hold values 0..n-1 (never zero bits).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [2:0] manual_cmd(input logic fwd, input logic back,
                                            input logic left, input logic right);
    if (fwd)        return CMD_FWD;
    else if (back)  return CMD_BACK;
    else if (left)  return CMD_LEFT;
    else if (right) return CMD_RIGHT;
    else            return CMD_STOP;
  endfunction

endpackage

// File: rtl/rover_debounce.sv
// Two-flop synchronizer followed by a counting debouncer; the stable value
// only flips after the synced input has differed for DEBOUNCE_CYCLES edges.
module rover_debounce
  import rover_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/rover_motion_encoder.sv
// Produces the registered active-low motion command from debounced manual
// buttons or from the obstacle-avoidance FSM in automated mode.
module rover_motion_encoder
  import rover_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BACKUP_CYCLES   = 50000000,
  parameter int TURN_CYCLES     = 30000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_forward,
  input  logic       btn_backward,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       auto_mode_switch,
  input  logic       object_detected,
  output logic       bit0,
  output logic       bit1,
  output logic       bit2,
  output logic [2:0] auto_state
);

  localparam int MAX_CYCLES = (BACKUP_CYCLES > TURN_CYCLES) ? BACKUP_CYCLES : TURN_CYCLES;
  localparam int CW = cnt_width(MAX_CYCLES);
  localparam logic [CW-1:0] BACKUP_LOAD = CW'(BACKUP_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LOAD   = CW'(TURN_CYCLES - 1);

  logic fwd_s, back_s, left_s, right_s, sw_s;
  logic obj_meta_q, obj_s_q;

  auto_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          mode_q;
  logic [2:0]    out_n_q;

  rover_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fwd (
    .clock(clock), .reset(reset), .raw_i(btn_forward), .stable_o(fwd_s));
  rover_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
    .clock(clock), .reset(reset), .raw_i(btn_backward), .stable_o(back_s));
  rover_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clock(clock), .reset(reset), .raw_i(btn_left), .stable_o(left_s));
  rover_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clock(clock), .reset(reset), .raw_i(btn_right), .stable_o(right_s));
  rover_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clock(clock), .reset(reset), .raw_i(auto_mode_switch), .stable_o(sw_s));

  // The obstacle sensor needs fast response, so it is synchronized but not debounced.
  always_ff @(posedge clock) begin
    if (reset) begin
      obj_meta_q <= 1'b0;
      obj_s_q    <= 1'b0;
    end else begin
      obj_meta_q <= object_detected;
      obj_s_q    <= obj_meta_q;
    end
  end

  // mode_q trails the debounced switch by one edge; a mismatch is a mode change,
  // which outranks both manual decoding and every FSM transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      out_n_q <= ~CMD_STOP;
    end else if (sw_s != mode_q) begin
      mode_q  <= sw_s;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_n_q <= ~CMD_STOP;
    end else if (!mode_q) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_n_q <= ~manual_cmd(fwd_s, back_s, left_s, right_s);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_FORWARD;
          out_n_q <= ~CMD_FWD;
        end
        ST_FORWARD: begin
          if (obj_s_q) begin
            state_q <= ST_BACKUP;
            cnt_q   <= BACKUP_LOAD;
            out_n_q <= ~CMD_BACK;
          end else begin
            out_n_q <= ~CMD_FWD;
          end
        end
        ST_BACKUP: begin
          if (cnt_q == '0) begin
            state_q <= ST_TURN;
            cnt_q   <= TURN_LOAD;
            out_n_q <= ~CMD_RIGHT;
          end else begin
            cnt_q   <= cnt_q - CW'(1);
            out_n_q <= ~CMD_BACK;
          end
        end
        ST_TURN: begin
          if (cnt_q != '0) begin
            cnt_q   <= cnt_q - CW'(1);
            out_n_q <= ~CMD_RIGHT;
          end else if (obj_s_q) begin
            cnt_q   <= TURN_LOAD;
            out_n_q <= ~CMD_RIGHT;
          end else begin
            state_q <= ST_FORWARD;
            out_n_q <= ~CMD_FWD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          out_n_q <= ~CMD_STOP;
        end
      endcase
    end
  end

  assign {bit2, bit1, bit0} = out_n_q;
  assign auto_state = state_q;

endmodule

// File: tb/tb_rover_motion_encoder.sv
// Self-checking bench for rover_motion_encoder: a scoreboard queue of
// cycle-stamped expectations, checked on the falling edge.
module tb_rover_motion_encoder;

  localparam int DEB = 4;
  localparam int BK  = 8;
  localparam int TN  = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btnForward = 1'b0, btnBackward = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
  logic       autoSwitch = 1'b0, objDetected = 1'b0;
  logic       bit0, bit1, bit2;
  logic [2:0] autoState;

  rover_motion_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .BACKUP_CYCLES(BK),
    .TURN_CYCLES(TN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_forward(btnForward),
    .btn_backward(btnBackward),
    .btn_left(btnLeft),
    .btn_right(btnRight),
    .auto_mode_switch(autoSwitch),
    .object_detected(objDetected),
    .bit0(bit0),
    .bit1(bit1),
    .bit2(bit2),
    .auto_state(autoState)
  );

  always #5 clock = ~clock;

  int cycCount = 0;
  always @(posedge clock) cycCount <= cycCount + 1;

  typedef struct {
    int         due;
    logic [2:0] bits;
    logic [2:0] st;
    string      tag;
  } expect_t;

  typedef struct {
    logic [3:0] btns;
    logic [2:0] expBits;
  } vec_t;

  expect_t sbQ[$];
  int checks = 0;
  int errors = 0;

  // Expectations are stamped with the edge count after which they must hold.
  always @(negedge clock) begin
    for (int i = sbQ.size() - 1; i >= 0; i--) begin
      if (sbQ[i].due == cycCount) begin
        checks++;
        if ({bit2, bit1, bit0} !== sbQ[i].bits || autoState !== sbQ[i].st) begin
          errors++;
          $display("[TB] FAIL %s @edge %0d: got bits=%b state=%0d, want bits=%b state=%0d",
                   sbQ[i].tag, cycCount, {bit2, bit1, bit0}, autoState, sbQ[i].bits, sbQ[i].st);
        end
        sbQ.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input int due, input logic [2:0] bits, input logic [2:0] st,
                             input string tag);
    expect_t e;
    e.due  = due;
    e.bits = bits;
    e.st   = st;
    e.tag  = tag;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] btns, input logic sw, input logic obj);
    {btnForward, btnBackward, btnLeft, btnRight} = btns;
    autoSwitch  = sw;
    objDetected = obj;
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    logic [2:0] prev;

    vecs[0] = '{4'b0000, 3'b111};
    vecs[1] = '{4'b0010, 3'b100};
    vecs[2] = '{4'b0000, 3'b111};
    vecs[3] = '{4'b1001, 3'b110};
    vecs[4] = '{4'b0001, 3'b011};
    vecs[5] = '{4'b1100, 3'b110};
    vecs[6] = '{4'b0110, 3'b101};
    vecs[7] = '{4'b0011, 3'b100};
    vecs[8] = '{4'b1111, 3'b110};
    vecs[9] = '{4'b0000, 3'b111};

    // Reset with every input high, then release: the mode switch and obstacle
    // also go live, so IDLE->FORWARD is immediately followed by BACKUP.
    applyStimulus(4'b1111, 1'b1, 1'b1);
    reset = 1'b1;
    for (int c = 1; c <= 3; c++) checkOutput(c, 3'b111, 3'd0, "resetHold");
    tick(3);
    reset = 1'b0;
    n = cycCount;
    for (int c = 1; c <= 7; c++) checkOutput(n + c, 3'b111, 3'd0, "postResetStop");
    checkOutput(n + 8, 3'b110, 3'd1, "autoForward");
    checkOutput(n + 9, 3'b101, 3'd2, "idleObjBackup");
    tick(9);

    // Reset mid-operation.
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    n = cycCount;
    checkOutput(n + 1, 3'b111, 3'd0, "midReset");
    checkOutput(n + 2, 3'b111, 3'd0, "midResetHold");
    tick(2);
    reset = 1'b0;
    n = cycCount;
    for (int c = 1; c <= 10; c++) checkOutput(n + c, 3'b111, 3'd0, "idleManual");
    tick(10);

    // Manual vectors: old value one edge before the latency point, new value at it.
    prev = 3'b111;
    for (int v = 0; v < 10; v++) begin
      n = cycCount;
      applyStimulus(vecs[v].btns, 1'b0, 1'b0);
      checkOutput(n + 6, prev, 3'd0, $sformatf("vec%0dOld", v));
      checkOutput(n + 7, vecs[v].expBits, 3'd0, $sformatf("vec%0dNew", v));
      prev = vecs[v].expBits;
      tick(10);
    end

    // Forward pulses shorter than the debounce window never register.
    n = cycCount;
    for (int c = 1; c <= 36; c++) checkOutput(n + c, 3'b111, 3'd0, "shortPulse");
    for (int k = 0; k < 6; k++) begin
      btnForward = 1'b1;
      tick(3);
      btnForward = 1'b0;
      tick(3);
    end

    // Enter automated mode.
    n = cycCount;
    autoSwitch = 1'b1;
    checkOutput(n + 6, 3'b111, 3'd0, "preModeEdge");
    checkOutput(n + 7, 3'b111, 3'd0, "modeStopAuto");
    checkOutput(n + 8, 3'b110, 3'd1, "autoFwd");
    checkOutput(n + 12, 3'b110, 3'd1, "autoFwdHold");
    tick(12);

    // A held button is ignored in automated mode.
    n = cycCount;
    btnLeft = 1'b1;
    for (int c = 1; c <= 10; c++) checkOutput(n + c, 3'b110, 3'd1, "autoIgnoresBtn");
    tick(10);

    // One-cycle obstacle pulse: BACK x8, RIGHT x6, then forward again.
    n = cycCount;
    objDetected = 1'b1;
    checkOutput(n + 2, 3'b110, 3'd1, "fwdBeforeObj");
    for (int c = 3; c <= 10; c++) checkOutput(n + c, 3'b101, 3'd2, "backup");
    for (int c = 11; c <= 16; c++) checkOutput(n + c, 3'b011, 3'd3, "turn");
    checkOutput(n + 17, 3'b110, 3'd1, "resumeFwd");
    checkOutput(n + 18, 3'b110, 3'd1, "resumeFwdHold");
    tick(1);
    objDetected = 1'b0;
    tick(19);

    // Obstacle still present when TURN expires: one extra TURN period.
    n = cycCount;
    objDetected = 1'b1;
    checkOutput(n + 2, 3'b110, 3'd1, "fwdBeforeObj2");
    for (int c = 3; c <= 10; c++) checkOutput(n + c, 3'b101, 3'd2, "backup2");
    for (int c = 11; c <= 22; c++) checkOutput(n + c, 3'b011, 3'd3, "extendedTurn");
    checkOutput(n + 23, 3'b110, 3'd1, "resumeAfterExt");
    checkOutput(n + 24, 3'b110, 3'd1, "resumeAfterExtHold");
    tick(18);
    objDetected = 1'b0;
    tick(7);

    // Switch dropped mid-BACKUP: one STOP cycle, then manual LEFT from the held button.
    n = cycCount;
    objDetected = 1'b1;
    checkOutput(n + 2, 3'b110, 3'd1, "fwdBeforeObj3");
    for (int c = 3; c <= 8; c++) checkOutput(n + c, 3'b101, 3'd2, "backup3");
    checkOutput(n + 9, 3'b111, 3'd0, "modeStopManual");
    for (int c = 10; c <= 12; c++) checkOutput(n + c, 3'b100, 3'd0, "manualLeftAfterAuto");
    tick(1);
    objDetected = 1'b0;
    tick(1);
    autoSwitch = 1'b0;
    tick(12);

    for (int i = 0; i < 50 && sbQ.size() > 0; i++) tick(1);
    if (sbQ.size() > 0) begin
      $display("[TB] FAIL scoreboardDrain: %0d expectations left unchecked, want 0", sbQ.size());
      errors += sbQ.size();
      checks += sbQ.size();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
